// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and helpers for the bit-serial adder
//
// Purpose: state type used by serial_adder's control FSM, plus a constant
//          ceil(log2) helper used to size the bit counter.
// Ports:   none (package).

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// rtl/serial_fa_bit.sv - combinational 1-bit full adder cell
//
// Purpose: single full-adder cell reused bit-serially by serial_adder.
// Ports:
//   x, y, z : addend bits and carry-in
//   s       : sum bit     (x ^ y ^ z)
//   c       : carry out   (majority of x, y, z)

module serial_fa_bit (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
//
// Purpose: samples a, b, cin on start, adds them one bit per clock through a
//          single full-adder cell and a carry flop, then presents the
//          registered sum/cout with a one-cycle done pulse.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : accept a, b, cin and begin an addition (honoured in IDLE and DONE)
//   a, b  : WIDTH-bit operands
//   cin   : carry into bit 0
//   busy  : high while bits are being shifted through the adder
//   done  : one-cycle pulse when sum/cout are updated
//   sum   : registered (a + b + cin) mod 2^WIDTH, held until next completion
//   cout  : registered carry out of bit WIDTH-1

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit so the count never wraps, even at WIDTH = 32.
  localparam int                CNT_W    = clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_c;

  serial_fa_bit u_fa (
    .x (a_sr_q[0]),
    .y (b_sr_q[0]),
    .z (carry_q),
    .s (fa_s),
    .c (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lines up.
        res_sr_d = WIDTH'({fa_s, res_sr_q} >> 1);
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = res_sr_d;
          cout_d  = fa_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)

module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a8),
    .b     (b8),
    .cin   (cin),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a8[0:0]),
    .b     (b8[0:0]),
    .cin   (cin),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: an accepted operation occupies the adder for W cycles,
  // then the arithmetic result a+b+cin appears with a one-cycle done.
  int  bl[2];
  int  full[2];
  int  esum[2];
  int  ecout[2];
  int  edone[2];
  bit  acc[2];
  bit  model_on;

  function automatic int wof(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  function automatic int opsum(input int w, input logic [7:0] x, input logic [7:0] y,
                               input logic c);
    int mask;
    mask = (1 << w) - 1;
    return (int'(x) & mask) + (int'(y) & mask) + int'(c);
  endfunction

  initial model_on = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        bl[k]    = 0;
        esum[k]  = 0;
        ecout[k] = 0;
        edone[k] = 0;
      end else begin
        acc[k]   = start && (bl[k] == 0);
        edone[k] = 0;
        if (bl[k] > 0) begin
          bl[k] = bl[k] - 1;
          if (bl[k] == 0) begin
            esum[k]  = full[k] % (1 << wof(k));
            ecout[k] = full[k] >> wof(k);
            edone[k] = 1;
          end
        end
        if (acc[k]) begin
          bl[k]   = wof(k);
          full[k] = opsum(wof(k), a8, b8, cin);
        end
      end
    end
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("w8_busy", 32'(busy8), (bl[0] > 0) ? 1 : 0);
      check("w8_done", 32'(done8), edone[0]);
      check("w8_sum",  32'(sum8),  esum[0]);
      check("w8_cout", 32'(cout8), ecout[0]);
      check("w1_busy", 32'(busy1), (bl[1] > 0) ? 1 : 0);
      check("w1_done", 32'(done1), edone[1]);
      check("w1_sum",  32'(sum1),  esum[1]);
      check("w1_cout", 32'(cout1), ecout[1]);
    end
  end

  task automatic run_op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                         input int es, input int ec, input string nm);
    int lat;
    int busy_n;
    a8 = xa; b8 = xb; cin = xc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done8 && lat < 30) begin
      if (busy8) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, 9);
    check({nm, "_busy_cycles"}, busy_n, 8);
    check({nm, "_sum"}, 32'(sum8), es);
    check({nm, "_cout"}, 32'(cout8), ec);
    @(negedge clk);
  endtask

  initial begin
    int dn;
    int dpos[4];
    int dsum[4];
    int dcout[4];
    int k1;
    int tot;

    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; a8 = '0; b8 = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy8), 0);
    check("reset_done", 32'(done8), 0);
    check("reset_sum",  32'(sum8),  0);
    check("reset_cout", 32'(cout8), 0);
    rst = 1'b0;
    @(negedge clk);

    run_op8(8'h00, 8'h00, 1'b0, 8'h00, 0, "zero");
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1, "ff_plus_1");
    run_op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1, "a5_5a_c1");
    run_op8(8'h3C, 8'h42, 1'b0, 8'h7E, 0, "3c_42");

    // start during SHIFT is ignored
    a8 = 8'h11; b8 = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'hF0; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      if (done8) begin
        dn++;
        dsum[0] = int'(sum8);
        dcout[0] = int'(cout8);
      end
      @(negedge clk);
    end
    check("ignore_done_count", dn, 1);
    check("ignore_sum", dsum[0], 8'h33);
    check("ignore_cout", dcout[0], 0);

    // reset aborts an operation in flight
    a8 = 8'hFF; b8 = 8'hFF; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy8), 0);
    check("abort_done", 32'(done8), 0);
    check("abort_sum",  32'(sum8),  0);
    check("abort_cout", 32'(cout8), 0);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("abort_no_done", dn, 0);

    // start held high: back-to-back acceptance every 9 cycles
    a8 = 8'h12; b8 = 8'h34; cin = 1'b0; start = 1'b1;
    dn = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin a8 = 8'h80; b8 = 8'h80; end
      if (k == 10) start = 1'b0;
      if (done8 && dn < 4) begin
        dpos[dn] = k;
        dsum[dn] = int'(sum8);
        dcout[dn] = int'(cout8);
        dn++;
      end
    end
    check("b2b_done_count", dn, 2);
    if (dn >= 2) begin
      check("b2b_pos0", dpos[0], 9);
      check("b2b_sum0", dsum[0], 8'h46);
      check("b2b_cout0", dcout[0], 0);
      check("b2b_pos1", dpos[1], 18);
      check("b2b_sum1", dsum[1], 8'h00);
      check("b2b_cout1", dcout[1], 1);
    end
    repeat (3) @(negedge clk);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      a8 = {7'b0, i[2]}; b8 = {7'b0, i[1]}; cin = i[0]; start = 1'b1;
      k1 = 0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) start = 1'b0;
        if (done1 && k1 == 0) begin
          k1 = k;
          tot = int'(i[2]) + int'(i[1]) + int'(i[0]);
          check("w1_tt_sum",  32'(sum1),  tot % 2);
          check("w1_tt_cout", 32'(cout1), tot / 2);
        end
      end
      check("w1_tt_latency", k1, 2);
    end
    repeat (10) @(negedge clk);

    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
